needs_scheduler: RTL and testbench

Time base and stat controller for the pet. Owns the five need counters (hunger, happiness, health, hygiene, energy) that feed the status decoder. Decays one need per game tick in round-robin order and serialises player actions through a valid/ready handshake with a post-action lockout. Freezes everything once any need saturates (death).

---
 rtl/tama_pkg.sv | 36 +++
 rtl/tick_prescaler.sv | 39 +++
 rtl/needs_scheduler.sv | 162 ++++++++++++++++
 tb/tb_needs_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tama_pkg.sv
// Shared constants for the pet: action codes, need indices, FSM encoding
// and the saturating need-update helper.
package tama_pkg;

  localparam logic [2:0] ACT_FEED  = 3'd0;
  localparam logic [2:0] ACT_PLAY  = 3'd1;
  localparam logic [2:0] ACT_MED   = 3'd2;
  localparam logic [2:0] ACT_CLEAN = 3'd3;
  localparam logic [2:0] ACT_SLEEP = 3'd4;

  localparam logic [2:0] NEED_HUNGER    = 3'd0;
  localparam logic [2:0] NEED_HAPPINESS = 3'd1;
  localparam logic [2:0] NEED_HEALTH    = 3'd2;
  localparam logic [2:0] NEED_HYGIENE   = 3'd3;
  localparam logic [2:0] NEED_ENERGY    = 3'd4;

  localparam logic [3:0] NEED_MAX = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOCK = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  // All deltas of one edge are summed first, then clamped once to 0..15.
  function automatic logic [3:0] sat_update(input logic [3:0] cur, input logic signed [5:0] delta);
    logic signed [5:0] sum;
    sum = $signed({2'b00, cur}) + delta;
    if (sum < 6'sd0) begin
      sat_update = 4'd0;
    end else if (sum > 6'sd15) begin
      sat_update = NEED_MAX;
    end else begin
      sat_update = sum[3:0];
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-cycle pulse on the last
// count of every TICK_DIV-cycle period.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // Next count with wrap at TICK_DIV-1.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Registered count; the pulse is aligned with the cycle holding LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/needs_scheduler.sv
// Owns the five need counters: round-robin decay on game ticks, player
// actions through a valid/ready handshake with lockout, and sticky death.
module needs_scheduler
  import tama_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int LOCK_CYCLES = 8,
  parameter int ACT_STEP    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       act_valid,
  input  logic [2:0] act_sel,
  output logic       act_ready,
  output logic [3:0] hunger,
  output logic [3:0] happiness,
  output logic [3:0] health,
  output logic [3:0] hygiene,
  output logic [3:0] energy,
  output logic       tick,
  output logic       dead
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic signed [5:0] STEP = $signed(6'(ACT_STEP));

  logic              tick_s;
  logic              fire_s;
  logic              live_s;
  logic              fatal_s;
  logic signed [5:0] delta_s [5];
  logic [3:0]        need_q  [5];
  logic [3:0]        need_d  [5];
  logic [1:0]        state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [LW-1:0]     lock_q, lock_d;
  logic              ready_q, ready_d;
  logic              dead_q, dead_d;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  assign live_s = (state_q != ST_DEAD);
  assign fire_s = act_valid && ready_q;

  // Sum decay and action deltas per need, then clamp once; frozen when dead.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      delta_s[i] = 6'sd0;
    end
    for (int i = 0; i < 5; i++) begin
      if (tick_s && live_s && (ptr_q == 3'(i))) begin
        delta_s[i] = delta_s[i] + 6'sd1;
      end else begin
        delta_s[i] = delta_s[i];
      end
    end
    if (fire_s) begin
      case (act_sel)
        ACT_FEED:  delta_s[NEED_HUNGER] = delta_s[NEED_HUNGER] - STEP;
        ACT_PLAY: begin
          delta_s[NEED_HAPPINESS] = delta_s[NEED_HAPPINESS] - STEP;
          delta_s[NEED_ENERGY]    = delta_s[NEED_ENERGY] + 6'sd1;
        end
        ACT_MED: begin
          delta_s[NEED_HEALTH]    = delta_s[NEED_HEALTH] - STEP;
          delta_s[NEED_HAPPINESS] = delta_s[NEED_HAPPINESS] + 6'sd1;
        end
        ACT_CLEAN: delta_s[NEED_HYGIENE] = delta_s[NEED_HYGIENE] - STEP;
        ACT_SLEEP: begin
          delta_s[NEED_ENERGY] = delta_s[NEED_ENERGY] - STEP;
          delta_s[NEED_HUNGER] = delta_s[NEED_HUNGER] + 6'sd1;
        end
        default: ;
      endcase
    end else begin
      fatal_s = 1'b0;
    end
    fatal_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (live_s) begin
        need_d[i] = sat_update(need_q[i], delta_s[i]);
      end else begin
        need_d[i] = need_q[i];
      end
      fatal_s = fatal_s | (live_s && (need_d[i] == NEED_MAX));
    end
  end

  // Handshake/lockout FSM; death overrides whatever the edge would do.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      ST_IDLE: begin
        if (fire_s) begin
          state_d = ST_LOCK;
          lock_d  = LW'(LOCK_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (lock_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          lock_d = lock_q - LW'(1);
        end
      end
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_IDLE;
    endcase
    if (fatal_s) begin
      state_d = ST_DEAD;
    end else begin
      state_d = state_d;
    end
    if (tick_s && live_s) begin
      ptr_d = (ptr_q == NEED_ENERGY) ? NEED_HUNGER : ptr_q + 3'd1;
    end else begin
      ptr_d = ptr_q;
    end
    ready_d = (state_d == ST_IDLE);
    dead_d  = dead_q | fatal_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= NEED_HUNGER;
      lock_q  <= '0;
      ready_q <= 1'b0;
      dead_q  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        need_q[i] <= 4'd0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      ready_q <= ready_d;
      dead_q  <= dead_d;
      for (int i = 0; i < 5; i++) begin
        need_q[i] <= need_d[i];
      end
    end
  end

  assign act_ready = ready_q;
  assign hunger    = need_q[NEED_HUNGER];
  assign happiness = need_q[NEED_HAPPINESS];
  assign health    = need_q[NEED_HEALTH];
  assign hygiene   = need_q[NEED_HYGIENE];
  assign energy    = need_q[NEED_ENERGY];
  assign tick      = tick_s;
  assign dead      = dead_q;

endmodule

// File: tb/tb_needs_scheduler.sv
// Random and directed stimulus for needs_scheduler, checked every cycle
// against a cycle-count based reference model of the pet's rules.
module tb_needs_scheduler;

  localparam int TD = 4;
  localparam int LC = 8;
  localparam int AS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       act_valid = 1'b0;
  logic [2:0] act_sel = 3'd0;
  logic       act_ready, tick, dead;
  logic [3:0] hunger, happiness, health, hygiene, energy;

  needs_scheduler #(.TICK_DIV(TD), .LOCK_CYCLES(LC), .ACT_STEP(AS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .act_valid (act_valid),
    .act_sel   (act_sel),
    .act_ready (act_ready),
    .hunger    (hunger),
    .happiness (happiness),
    .health    (health),
    .hygiene   (hygiene),
    .energy    (energy),
    .tick      (tick),
    .dead      (dead)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: needs indexed hunger, happiness, health, hygiene, energy.
  int m_need [5];
  int m_ptr;
  int m_cyc;
  int m_ready_from;
  bit m_dead;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic bit m_ready();
    return !m_dead && (m_cyc >= m_ready_from);
  endfunction

  function automatic bit m_tick();
    return (m_cyc % TD) == (TD - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_need[i] = 0;
    m_ptr = 0;
    m_cyc = 0;
    m_ready_from = 1;
    m_dead = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [2:0] s);
    int d [5];
    bit fire;
    bit t;
    bit any15;
    fire = v && m_ready();
    t = m_tick();
    any15 = 1'b0;
    if (!m_dead) begin
      for (int i = 0; i < 5; i++) d[i] = 0;
      if (t) d[m_ptr] += 1;
      if (fire) begin
        case (s)
          3'd0: d[0] -= AS;
          3'd1: begin d[1] -= AS; d[4] += 1; end
          3'd2: begin d[2] -= AS; d[1] += 1; end
          3'd3: d[3] -= AS;
          3'd4: begin d[4] -= AS; d[0] += 1; end
          default: ;
        endcase
        m_ready_from = m_cyc + 1 + LC;
      end
      for (int i = 0; i < 5; i++) begin
        m_need[i] = m_need[i] + d[i];
        if (m_need[i] < 0) m_need[i] = 0;
        if (m_need[i] > 15) m_need[i] = 15;
        if (m_need[i] == 15) any15 = 1'b1;
      end
      if (t) m_ptr = (m_ptr + 1) % 5;
      if (any15) m_dead = 1'b1;
    end
    m_cyc++;
  endtask

  task automatic check_all();
    check_eq("tick", int'(tick), int'(m_tick()));
    check_eq("act_ready", int'(act_ready), int'(m_ready()));
    check_eq("dead", int'(dead), int'(m_dead));
    check_eq("hunger", int'(hunger), m_need[0]);
    check_eq("happiness", int'(happiness), m_need[1]);
    check_eq("health", int'(health), m_need[2]);
    check_eq("hygiene", int'(hygiene), m_need[3]);
    check_eq("energy", int'(energy), m_need[4]);
  endtask

  // Called at a negedge: check, drive, take the rising edge, return at next negedge.
  task automatic cycle(input bit v, input logic [2:0] s);
    check_all();
    act_valid = v;
    act_sel = s;
    @(posedge clk);
    model_edge(v, s);
    @(negedge clk);
  endtask

  // Called at a negedge: reset asserted between edges, outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    act_valid = 1'b0;
    #1;
    check_eq("rst_ready", int'(act_ready), 0);
    check_eq("rst_tick", int'(tick), 0);
    check_eq("rst_dead", int'(dead), 0);
    check_eq("rst_needs", int'(hunger) + int'(happiness) + int'(health) + int'(hygiene) + int'(energy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Five ticks land in cycles 3..19; a sixth at 23 bumps hunger again.
    repeat (20) cycle(1'b0, 3'd0);
    check_eq("after5_hunger", int'(hunger), 1);
    check_eq("after5_energy", int'(energy), 1);
    check_eq("after5_hygiene", int'(hygiene), 1);
    repeat (4) cycle(1'b0, 3'd0);
    check_eq("after6_hunger", int'(hunger), 2);

    // Single feed, then lockout observed by the model.
    cycle(1'b1, 3'd0);
    check_eq("feed_hunger", int'(hunger), 0);
    repeat (12) cycle(1'b0, 3'd0);

    // Held play: one acceptance every LC+1 cycles.
    repeat (40) cycle(1'b1, 3'd1);
    act_valid = 1'b0;
    repeat (3) cycle(1'b0, 3'd0);

    // Reserved code is accepted without touching any need.
    while (!m_ready()) cycle(1'b0, 3'd0);
    cycle(1'b1, 3'd6);
    repeat (3) cycle(1'b0, 3'd0);

    // Reset mid-LOCK, then check the tick phase restarts.
    do_reset();
    repeat (2) cycle(1'b0, 3'd0);
    cycle(1'b1, 3'd3);
    repeat (3) cycle(1'b0, 3'd0);
    do_reset();
    repeat (8) cycle(1'b0, 3'd0);

    // Random traffic across several lives.
    for (int k = 0; k < 4; k++) begin
      do_reset();
      repeat (400) cycle($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
    end

    // Neglect until death, then actions and ticks must change nothing.
    do_reset();
    repeat (300) cycle(1'b0, 3'd0);
    check_eq("neglect_dead", int'(dead), 1);
    check_eq("neglect_hunger", int'(hunger), 15);
    repeat (30) cycle(1'b1, 3'($urandom_range(0, 4)));
    check_eq("dead_ready", int'(act_ready), 0);
    do_reset();
    repeat (5) cycle(1'b0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
